// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD down counter with an internal tick prescaler.
// Loads a clamped BCD preset, counts down once per tick, and flags expiry at zero.
module bcd_countdown_timer #(
  parameter int                  DIGITS    = 2,
  parameter int                  TICK_DIV  = 50000000,
  parameter logic [4*DIGITS-1:0] START_BCD = 'h30
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   Preset,
  input  logic                  Start,
  input  logic                  Pause,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  Tick,
  output logic                  Running,
  output logic                  Done,
  output logic                  Expired
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSED,
    ST_EXPIRED
  } state_t;

  // Any nibble above 9 saturates to 9 so Q never holds a non-decimal digit.
  function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  localparam logic [W-1:0] START_VAL = clamp_bcd(START_BCD);

  state_t        state_q, state_d;
  logic [W-1:0]  q_q, q_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          done_q, done_d;
  logic          running_q;
  logic          expired_q;

  logic [DIGITS:0] borrow;
  logic [W-1:0]    q_dec;
  logic [W-1:0]    q_dec_sat;
  logic [W-1:0]    preset_clamped;
  logic            q_is_zero;
  logic            dec_is_zero;

  // Borrow ripples from digit 0 upward; a borrow out of the top digit means Q was zero.
  assign borrow[0] = 1'b1;
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [3:0] dig;
    assign dig = q_q[4*gi +: 4];
    assign q_dec[4*gi +: 4] = !borrow[gi]     ? dig  :
                              (dig == 4'd0)   ? 4'd9 : dig - 4'd1;
    assign borrow[gi+1] = borrow[gi] & (dig == 4'd0);
  end

  assign q_is_zero      = borrow[DIGITS];
  assign q_dec_sat      = q_is_zero ? '0 : q_dec;
  assign dec_is_zero    = ~|q_dec_sat;
  assign preset_clamped = clamp_bcd(Preset);

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;

    if (Load) begin
      q_d     = preset_clamped;
      presc_d = '0;
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!Pause && Start) begin
            presc_d = '0;
            state_d = q_is_zero ? ST_EXPIRED : ST_RUN;
          end
        end
        ST_RUN: begin
          if (Pause) begin
            state_d = ST_PAUSED;
          end else if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            tick_d  = 1'b1;
            q_d     = q_dec_sat;
            if (dec_is_zero) begin
              done_d  = 1'b1;
              state_d = ST_EXPIRED;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        ST_PAUSED: begin
          // Prescaler keeps its value so the partial tick period is honoured on resume.
          if (!Pause && Start) state_d = ST_RUN;
        end
        ST_EXPIRED: begin
          if (!Pause && Start) begin
            q_d     = START_VAL;
            presc_d = '0;
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      q_q       <= START_VAL;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
      running_q <= (state_d == ST_RUN);
      expired_q <= (state_d == ST_EXPIRED);
    end
  end

  assign Q       = q_q;
  assign Tick    = tick_q;
  assign Done    = done_q;
  assign Running = running_q;
  assign Expired = expired_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Randomized bench for bcd_countdown_timer against an integer-valued reference model.
module tb_bcd_countdown_timer;

  localparam int TD = 4;

  logic       Clock;
  logic       Reset;
  logic       Load;
  logic [7:0] Preset;
  logic       Start;
  logic       Pause;
  logic [7:0] Q;
  logic       Tick;
  logic       Running;
  logic       Done;
  logic       Expired;

  bcd_countdown_timer #(
    .DIGITS   (2),
    .TICK_DIV (TD),
    .START_BCD(8'h30)
  ) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Load   (Load),
    .Preset (Preset),
    .Start  (Start),
    .Pause  (Pause),
    .Q      (Q),
    .Tick   (Tick),
    .Running(Running),
    .Done   (Done),
    .Expired(Expired)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: count held as a plain decimal integer.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXPIRED = 3;
  int m_val, m_presc, m_mode;
  bit m_tick, m_done;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic int preset_value(input logic [7:0] p);
    int hi, lo;
    hi = int'(p[7:4]);
    lo = int'(p[3:0]);
    if (hi > 9) hi = 9;
    if (lo > 9) lo = 9;
    return hi * 10 + lo;
  endfunction

  task automatic model_reset();
    m_val   = 30;
    m_presc = 0;
    m_mode  = M_IDLE;
    m_tick  = 0;
    m_done  = 0;
  endtask

  task automatic model_step(input bit ld, input logic [7:0] pre, input bit st, input bit pz);
    m_tick = 0;
    m_done = 0;
    if (ld) begin
      m_val   = preset_value(pre);
      m_presc = 0;
      m_mode  = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: if (!pz && st) begin
          m_presc = 0;
          m_mode  = (m_val == 0) ? M_EXPIRED : M_RUN;
        end
        M_RUN: begin
          if (pz) m_mode = M_PAUSED;
          else if (m_presc == TD - 1) begin
            m_presc = 0;
            m_tick  = 1;
            if (m_val > 0) m_val = m_val - 1;
            if (m_val == 0) begin
              m_done = 1;
              m_mode = M_EXPIRED;
            end
          end else m_presc = m_presc + 1;
        end
        M_PAUSED: if (!pz && st) m_mode = M_RUN;
        default: if (!pz && st) begin
          m_val   = 30;
          m_presc = 0;
          m_mode  = M_RUN;
        end
      endcase
    end
  endtask

  task automatic check_outputs();
    check("q", 32'(Q), 32'(to_bcd(m_val)));
    check("tick", 32'(Tick), 32'(m_tick));
    check("done", 32'(Done), 32'(m_done));
    check("running", 32'(Running), 32'(m_mode == M_RUN));
    check("expired", 32'(Expired), 32'(m_mode == M_EXPIRED));
  endtask

  // Called at a falling edge: drive inputs, advance model across the next rising edge, re-check.
  task automatic step(input bit ld, input logic [7:0] pre, input bit st, input bit pz);
    Load   = ld;
    Preset = pre;
    Start  = st;
    Pause  = pz;
    if (ld) $display("txn load preset=%02h expect_q=%02h", pre, to_bcd(preset_value(pre)));
    model_step(ld, pre, st, pz);
    @(negedge Clock);
    check_outputs();
  endtask

  // Asserts reset in the low phase and checks outputs before any further clock edge.
  task automatic async_reset();
    #2 Reset = 1'b0;
    #1;
    model_reset();
    $display("txn async_reset");
    check("rst_q", 32'(Q), 32'h30);
    check("rst_flags", 32'({Tick, Running, Done, Expired}), 32'h0);
    @(negedge Clock);
    check_outputs();
    Reset = 1'b1;
  endtask

  initial begin
    bit         ld, st, pz;
    logic [7:0] pre;
    int         r;

    Reset  = 1'b0;
    Load   = 1'b0;
    Preset = 8'h00;
    Start  = 1'b0;
    Pause  = 1'b0;
    model_reset();
    @(negedge Clock);
    @(negedge Clock);
    check_outputs();
    Reset = 1'b1;

    $display("txn idle_50");
    for (int i = 0; i < 50; i++) step(0, 8'h00, 0, 0);
    check("idle_q", 32'(Q), 32'h30);

    step(1, 8'h12, 0, 0);
    step(0, 8'h00, 1, 0);
    for (int i = 0; i < 12; i++) step(0, 8'h00, 1, 0);
    check("borrow_q", 32'(Q), 32'h09);
    check("borrow_tick", 32'(Tick), 32'h1);

    step(1, 8'h01, 0, 0);
    step(0, 8'h00, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 0);
    check("expire_q", 32'(Q), 32'h00);
    check("expire_done", 32'(Done), 32'h1);
    check("expire_flag", 32'(Expired), 32'h1);
    for (int i = 0; i < 40; i++) step(0, 8'h00, 0, 0);
    check("expire_hold_q", 32'(Q), 32'h00);
    check("expire_done_pulse", 32'(Done), 32'h0);

    step(1, 8'h50, 0, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 8'h00, 0, 1);
    check("paused_q", 32'(Q), 32'h50);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    check("resume_no_tick", 32'(Tick), 32'h0);
    step(0, 8'h00, 1, 0);
    check("resume_tick", 32'(Tick), 32'h1);
    check("resume_q", 32'(Q), 32'h49);

    step(1, 8'hAF, 0, 0);
    check("clamp_q", 32'(Q), 32'h99);
    step(0, 8'h00, 1, 0);
    step(1, 8'h55, 1, 0);
    check("load_start_run", 32'(Running), 32'h0);

    step(1, 8'h07, 0, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    async_reset();
    for (int i = 0; i < 10; i++) step(0, 8'h00, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      r  = int'($urandom_range(0, 199));
      ld = (r < 5);
      if ($urandom_range(0, 1) == 1) pre = 8'($urandom_range(0, 255));
      else pre = 8'($urandom_range(0, 3));
      st = ($urandom_range(0, 3) != 0);
      pz = ($urandom_range(0, 9) == 0);
      if (r == 199) async_reset();
      else step(ld, pre, st, pz);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
